// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp
//  Purpose  : Register file with 2 async read ports, 2 clocked write ports,
//             an optional zero register, optional write-to-read bypass and a
//             per-register busy scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 0
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    output logic                  ReadBusy1,
    output logic                  ReadBusy2,
    input  logic [ADDR_WIDTH-1:0] WriteRegister0,
    input  logic [DATA_WIDTH-1:0] WriteData0,
    input  logic                  RegWrite0,
    input  logic [ADDR_WIDTH-1:0] WriteRegister1,
    input  logic [DATA_WIDTH-1:0] WriteData1,
    input  logic                  RegWrite1,
    input  logic                  Reserve,
    input  logic [ADDR_WIDTH-1:0] ReserveRegister,
    output logic                  ReserveFail
);

    localparam int c_depth = 2 ** ADDR_WIDTH;
    localparam bit c_zero  = (ZERO_REG != 0);
    localparam bit c_bypass = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] r_mem [c_depth];
    logic [c_depth-1:0]    r_busy;

    logic                         w_wr0_en;
    logic                         w_wr1_en;
    logic                         w_rsv_zero;
    logic                         w_rsv_hit_write;
    logic                         w_rsv_accept;
    logic [1:0][ADDR_WIDTH-1:0]   w_raddr;
    logic [1:0][DATA_WIDTH-1:0]   w_rdata;

    // Writes aimed at a hardwired zero register are dropped before they reach state.
    assign w_wr0_en = RegWrite0 && !(c_zero && (WriteRegister0 == '0));
    assign w_wr1_en = RegWrite1 && !(c_zero && (WriteRegister1 == '0));

    assign w_rsv_zero      = c_zero && (ReserveRegister == '0);
    assign w_rsv_hit_write = (RegWrite0 && (WriteRegister0 == ReserveRegister)) ||
                             (RegWrite1 && (WriteRegister1 == ReserveRegister));

    // A reserve on a busy register succeeds if that register is being released now.
    assign ReserveFail  = Reserve && !w_rsv_zero && r_busy[ReserveRegister] && !w_rsv_hit_write;
    assign w_rsv_accept = Reserve && !w_rsv_zero && !ReserveFail;

    assign w_raddr = {ReadRegister2, ReadRegister1};

    generate
        for (genvar k = 0; k < 2; k++) begin : g_read_port
            logic w_hit0;
            logic w_hit1;
            assign w_hit0 = c_bypass && w_wr0_en && (WriteRegister0 == w_raddr[k]);
            assign w_hit1 = c_bypass && w_wr1_en && (WriteRegister1 == w_raddr[k]);
            assign w_rdata[k] = (c_zero && (w_raddr[k] == '0)) ? '0         :
                                w_hit1                          ? WriteData1 :
                                w_hit0                          ? WriteData0 :
                                                                  r_mem[w_raddr[k]];
        end
    endgenerate

    assign ReadData1 = w_rdata[0];
    assign ReadData2 = w_rdata[1];
    assign ReadBusy1 = r_busy[ReadRegister1];
    assign ReadBusy2 = r_busy[ReadRegister2];

    // Port 1 is applied after port 0 so it wins on a shared address; an accepted
    // reserve is applied last so it overrides the busy clear of a same-cycle write.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wr0_en) begin
                r_mem[WriteRegister0]  <= WriteData0;
                r_busy[WriteRegister0] <= 1'b0;
            end
            if (w_wr1_en) begin
                r_mem[WriteRegister1]  <= WriteData1;
                r_busy[WriteRegister1] <= 1'b0;
            end
            if (w_rsv_accept) begin
                r_busy[ReserveRegister] <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_mp
//  Purpose  : Self-checking bench for regfile_mp across three configurations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [4:0]  ra1, ra2, wa0, wa1, rsa;
    logic [31:0] wd0, wd1;
    logic        we0, we1, rsv;

    // Instance 0: zero reg, no bypass; 1: zero reg, bypass; 2: no zero reg, no bypass
    logic [31:0] rd1 [3];
    logic [31:0] rd2 [3];
    logic        rb1 [3];
    logic        rb2 [3];
    logic        rf  [3];

    localparam bit [2:0] ZM = 3'b011;
    localparam bit [2:0] BM = 3'b010;

    regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(0)) u_z1b0 (
        .Clk(clk), .Reset_n(rst_n),
        .ReadRegister1(ra1), .ReadRegister2(ra2),
        .ReadData1(rd1[0]), .ReadData2(rd2[0]), .ReadBusy1(rb1[0]), .ReadBusy2(rb2[0]),
        .WriteRegister0(wa0), .WriteData0(wd0), .RegWrite0(we0),
        .WriteRegister1(wa1), .WriteData1(wd1), .RegWrite1(we1),
        .Reserve(rsv), .ReserveRegister(rsa), .ReserveFail(rf[0])
    );

    regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) u_z1b1 (
        .Clk(clk), .Reset_n(rst_n),
        .ReadRegister1(ra1), .ReadRegister2(ra2),
        .ReadData1(rd1[1]), .ReadData2(rd2[1]), .ReadBusy1(rb1[1]), .ReadBusy2(rb2[1]),
        .WriteRegister0(wa0), .WriteData0(wd0), .RegWrite0(we0),
        .WriteRegister1(wa1), .WriteData1(wd1), .RegWrite1(we1),
        .Reserve(rsv), .ReserveRegister(rsa), .ReserveFail(rf[1])
    );

    regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0), .BYPASS(0)) u_z0b0 (
        .Clk(clk), .Reset_n(rst_n),
        .ReadRegister1(ra1), .ReadRegister2(ra2),
        .ReadData1(rd1[2]), .ReadData2(rd2[2]), .ReadBusy1(rb1[2]), .ReadBusy2(rb2[2]),
        .WriteRegister0(wa0), .WriteData0(wd0), .RegWrite0(we0),
        .WriteRegister1(wa1), .WriteData1(wd1), .RegWrite1(we1),
        .Reserve(rsv), .ReserveRegister(rsa), .ReserveFail(rf[2])
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference state: plain arrays updated from the rules at each clock edge.
    logic [31:0] mem  [3][32];
    bit          busy [3][32];
    bit          mvalid = 1'b0;

    function automatic logic [31:0] exp_rd(input int i, input logic [4:0] a);
        if (ZM[i] && a == 5'd0)            return 32'd0;
        if (BM[i] && we1 && wa1 == a)      return wd1;
        if (BM[i] && we0 && wa0 == a)      return wd0;
        return mem[i][a];
    endfunction

    function automatic bit exp_rf(input int i);
        return rsv && !(ZM[i] && rsa == 5'd0) && busy[i][rsa] &&
               !(we0 && wa0 == rsa) && !(we1 && wa1 == rsa);
    endfunction

    // Inputs are stable from just after one posedge to the next, so at the negedge
    // the outputs are checked and the model advances to the state of the coming edge.
    always @(negedge clk) begin
        if (mvalid) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d.ReadData1", i), rd1[i], exp_rd(i, ra1));
                chk($sformatf("u%0d.ReadData2", i), rd2[i], exp_rd(i, ra2));
                chk($sformatf("u%0d.ReadBusy1", i), 32'(rb1[i]), 32'(busy[i][ra1]));
                chk($sformatf("u%0d.ReadBusy2", i), 32'(rb2[i]), 32'(busy[i][ra2]));
                chk($sformatf("u%0d.ReserveFail", i), 32'(rf[i]), 32'(exp_rf(i)));
            end
        end
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 32; j++) begin
                    mem[i][j]  = 32'd0;
                    busy[i][j] = 1'b0;
                end
            end
            mvalid = 1'b1;
        end else if (mvalid) begin
            for (int i = 0; i < 3; i++) begin
                bit acc;
                acc = rsv && !exp_rf(i) && !(ZM[i] && rsa == 5'd0);
                if (we0 && !(ZM[i] && wa0 == 5'd0)) begin
                    mem[i][wa0]  = wd0;
                    busy[i][wa0] = 1'b0;
                end
                if (we1 && !(ZM[i] && wa1 == 5'd0)) begin
                    mem[i][wa1]  = wd1;
                    busy[i][wa1] = 1'b0;
                end
                if (acc) busy[i][rsa] = 1'b1;
            end
        end
    end

    task automatic idle();
        rst_n = 1'b1;
        we0 = 1'b0; wa0 = 5'd0; wd0 = 32'd0;
        we1 = 1'b0; wa1 = 5'd0; wd1 = 32'd0;
        rsv = 1'b0; rsa = 5'd0;
        ra1 = 5'd0; ra2 = 5'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) tick();

        idle(); we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hDEAD;
        @(negedge clk);

        tick(); idle(); rst_n = 1'b0; ra1 = 5'd7;
        @(negedge clk);
        chk("pre_reset_r7", rd1[0], 32'hDEAD);

        tick(); idle(); ra1 = 5'd7;
        @(negedge clk);
        chk("reset_r7_data", rd1[0], 32'd0);
        chk("reset_r7_busy", 32'(rb1[0]), 32'd0);

        tick(); idle();
        we0 = 1'b1; wa0 = 5'd2; wd0 = 32'd42;
        we1 = 1'b1; wa1 = 5'd2; wd1 = 32'd15;
        ra1 = 5'd2; ra2 = 5'd2;
        @(negedge clk);
        chk("bypass_port1_wins", rd1[1], 32'd15);
        chk("nobypass_old_r2", rd1[0], 32'd0);

        tick(); idle(); ra1 = 5'd2; ra2 = 5'd2; wa0 = 5'd1; wd0 = 32'd5;
        @(negedge clk);
        chk("dual_write_rd1", rd1[0], 32'd15);
        chk("dual_write_rd2", rd2[0], 32'd15);

        tick(); idle(); ra1 = 5'd1; ra2 = 5'd2;
        @(negedge clk);
        chk("disabled_write_r1", rd1[0], 32'd0);
        chk("r2_kept", rd2[0], 32'd15);

        tick(); idle();
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'd1000;
        rsv = 1'b1; rsa = 5'd0; ra1 = 5'd0;
        @(negedge clk);
        chk("zero_reserve_fail", 32'(rf[0]), 32'd0);

        tick(); idle(); ra1 = 5'd0;
        @(negedge clk);
        chk("zero_reg_data", rd1[0], 32'd0);
        chk("zero_reg_busy", 32'(rb1[0]), 32'd0);
        chk("r0_plain_data", rd1[2], 32'd1000);
        chk("r0_plain_busy", 32'(rb1[2]), 32'd1);

        tick(); idle(); rsv = 1'b1; rsa = 5'd10; ra2 = 5'd10;
        @(negedge clk);
        chk("reserve_r10_ok", 32'(rf[0]), 32'd0);

        tick(); idle(); rsv = 1'b1; rsa = 5'd10; ra2 = 5'd10;
        @(negedge clk);
        chk("r10_busy", 32'(rb2[0]), 32'd1);
        chk("reserve_r10_again", 32'(rf[0]), 32'd1);

        tick(); idle(); we0 = 1'b1; wa0 = 5'd10; wd0 = 32'd10; ra1 = 5'd10;
        @(negedge clk);

        tick(); idle(); ra1 = 5'd10;
        we1 = 1'b1; wa1 = 5'd11; wd1 = 32'd11; rsv = 1'b1; rsa = 5'd11;
        @(negedge clk);
        chk("r10_written", rd1[0], 32'd10);
        chk("r10_released", 32'(rb1[0]), 32'd0);

        tick(); idle(); ra1 = 5'd11;
        rsv = 1'b1; rsa = 5'd11; we0 = 1'b1; wa0 = 5'd11; wd0 = 32'd7;
        @(negedge clk);
        chk("r11_data", rd1[0], 32'd11);
        chk("r11_busy", 32'(rb1[0]), 32'd1);
        chk("reserve_busy_written", 32'(rf[0]), 32'd0);

        tick(); idle();
        we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h55;
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h77;
        ra1 = 5'd5; ra2 = 5'd0;
        @(negedge clk);
        chk("bypass_r5", rd1[1], 32'h55);
        chk("nobypass_r5", rd1[0], 32'd0);
        chk("bypass_r0_blocked", rd2[1], 32'd0);

        for (int n = 0; n < 3000; n++) begin
            tick();
            rst_n = ($urandom_range(0, 99) != 0);
            we0 = ($urandom_range(0, 9) < 4); wa0 = rand_addr(); wd0 = $urandom;
            we1 = ($urandom_range(0, 9) < 4); wa1 = rand_addr(); wd1 = $urandom;
            rsv = ($urandom_range(0, 1) == 1); rsa = rand_addr();
            ra1 = rand_addr(); ra2 = rand_addr();
        end

        tick(); idle();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
